// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM BIST master.
//   - bist_state_t : controller states
//   - DEF_BASE_ADDR / DEF_SEED : default window base and pattern seed
//   - bist_pattern : expected byte for a given location index
package ram_bist_pkg;

  localparam logic [15:0] DEF_BASE_ADDR = 16'h8000;
  localparam logic [7:0]  DEF_SEED      = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } bist_state_t;

  function automatic logic [7:0] bist_pattern(input logic [7:0] idx,
                                              input logic [7:0] seed);
    return idx ^ seed;
  endfunction

endpackage

// File: rtl/ram_bist_checker.sv
// Read-back comparator for the RAM BIST master.
// Ports:
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_clear            : clears the results at the start of a run
//   i_cmp_valid        : i_rdata is due for comparison this cycle
//   i_exp_data         : expected byte for the location being compared
//   i_exp_addr         : address of the location being compared
//   i_rdata            : RAM read data
//   o_err_count        : mismatches seen since the last clear
//   o_first_fail_addr  : address of the first mismatch since the last clear
module ram_bist_checker #(
  parameter int unsigned CW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_cmp_valid,
  input  logic [7:0]    i_exp_data,
  input  logic [15:0]   i_exp_addr,
  input  logic [7:0]    i_rdata,
  output logic [CW-1:0] o_err_count,
  output logic [15:0]   o_first_fail_addr
);

  logic          w_mismatch;
  logic [CW-1:0] r_err_count;
  logic [15:0]   r_first_fail_addr;

  assign w_mismatch = i_cmp_valid && (i_rdata != i_exp_data);

  // Counter width holds DEPTH, and at most DEPTH compares occur per run.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_err_count       <= '0;
      r_first_fail_addr <= '0;
    end else if (w_mismatch) begin
      r_err_count <= r_err_count + 1'b1;
      if (r_err_count == '0) begin
        r_first_fail_addr <= i_exp_addr;
      end
    end
  end

  assign o_err_count       = r_err_count;
  assign o_first_fail_addr = r_first_fail_addr;

endmodule

// File: rtl/ram_bist_master.sv
// RAM BIST master: writes idx^SEED to DEPTH locations from BASE_ADDR, reads
// them back and reports pass / error count / first failing address.
// Ports:
//   clk, rst        : clock (shared with RAM), synchronous active-high reset
//   start           : run request, honoured only in IDLE
//   ram_address     : RAM address (BASE_ADDR when not writing/reading)
//   ram_wdata       : RAM write data (0 outside WRITE)
//   ram_we          : RAM write enable
//   ram_rdata       : RAM read data, valid one cycle after the read address
//   busy            : high in WRITE, READ and DRAIN
//   done            : one-cycle end-of-run pulse
//   pass            : last completed run had no mismatches
//   err_count       : mismatches in last run
//   first_fail_addr : address of first mismatch in last run
module ram_bist_master
  import ram_bist_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned DEPTH     = 16,
  parameter logic [7:0]  SEED      = DEF_SEED
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [15:0]                  ram_address,
  output logic [7:0]                   ram_wdata,
  output logic                         ram_we,
  input  logic [7:0]                   ram_rdata,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [$clog2(DEPTH+1)-1:0]   err_count,
  output logic [15:0]                  first_fail_addr
);

  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam logic [7:0]  LAST = 8'(DEPTH - 1);

  bist_state_t r_state;
  bist_state_t w_next_state;
  logic [7:0]  r_idx;
  logic        r_cmp_valid;
  logic [7:0]  r_exp_data;
  logic [15:0] r_exp_addr;
  logic        r_pass;
  logic        w_clear;
  logic        w_idx_last;
  logic [15:0] w_idx_addr;

  assign w_clear    = (r_state == S_IDLE) && start;
  assign w_idx_last = (r_idx == LAST);
  assign w_idx_addr = BASE_ADDR + {8'h00, r_idx};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    ram_we       = 1'b0;
    ram_address  = BASE_ADDR;
    ram_wdata    = 8'h00;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_WRITE;
      end
      S_WRITE: begin
        ram_we      = 1'b1;
        ram_address = w_idx_addr;
        ram_wdata   = bist_pattern(r_idx, SEED);
        busy        = 1'b1;
        if (w_idx_last) w_next_state = S_READ;
      end
      S_READ: begin
        ram_address = w_idx_addr;
        busy        = 1'b1;
        if (w_idx_last) w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        busy         = 1'b1;
        w_next_state = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
    end else if ((r_state == S_WRITE || r_state == S_READ) && !w_idx_last) begin
      r_idx <= r_idx + 8'd1;
    end else begin
      r_idx <= '0;
    end
  end

  // Expected data/address trail the read address by one cycle so that they
  // line up with the RAM's registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmp_valid <= 1'b0;
      r_exp_data  <= '0;
      r_exp_addr  <= '0;
    end else begin
      r_cmp_valid <= (r_state == S_READ);
      r_exp_data  <= bist_pattern(r_idx, SEED);
      r_exp_addr  <= w_idx_addr;
    end
  end

  ram_bist_checker #(
    .CW (CW)
  ) u_checker (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_clear           (w_clear),
    .i_cmp_valid       (r_cmp_valid),
    .i_exp_data        (r_exp_data),
    .i_exp_addr        (r_exp_addr),
    .i_rdata           (ram_rdata),
    .o_err_count       (err_count),
    .o_first_fail_addr (first_fail_addr)
  );

  // The last compare lands in DRAIN, so err_count is final during DONE.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_pass <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_pass <= (err_count == '0);
    end
  end

  assign pass = r_pass;

endmodule
